mem_cmd_scheduler: RTL and testbench
====================================

MEM_CMD_SCHEDULER -- requirements
Module: mem_cmd_scheduler

Interface
REQ-001 clk  input  1  command clock; all timing counts are in clk cycles.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  a queued CPU request is presented.
REQ-004 req_ready  output  1  scheduler accepts the request; transfer occurs on req_valid & req_ready.
REQ-005 req_mode  input  4  0 = data read, 1 = data write, 2 = instruction fetch (treated as read); other values are treated as read.
REQ-006 req_addr  input  36  row [35:18], column [17:10], bank [9:8], bankGroup [7:6]; [5:0] are ignored.
REQ-007 cmd_valid  output  1  one-cycle pulse marking a DRAM command.
REQ-008 cmd_type  output  2  dramCmd: PRE=00, ACT=01, RD=10, WR=11.
REQ-009 cmd_bg / cmd_bank / cmd_row / cmd_col  output  2/2/18/8  command target; cmd_row is valid for ACT, cmd_col is valid for RD/WR.
REQ-010 req_done  output  1  one-cycle pulse in the cycle the request's RD/WR is issued.

Function
REQ-011 Timing parameters come from the shared package: tRP=24, tRCD=24, tWR=20, tRTP=12, tCCD_L=8.
REQ-012 The scheduler uses an open-page policy, serves requests in order, and has one request outstanding.
REQ-013 The scheduler keeps a 16-entry open-row table indexed {bankGroup,bank}; each entry holds an open bit and an 18-bit row.
REQ-014 FSM states: IDLE, DECODE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS.
REQ-015 req_ready is 1 only in IDLE.
REQ-016 Acceptance moves IDLE to DECODE and latches mode and the decoded address fields.
REQ-017 DECODE classifies the request:
- hit (bank open, same row) -> CAS
- empty (bank closed) -> ACT
- conflict (bank open, different row) -> PRE
REQ-018 PRE waits until the bank's precharge-eligibility counter is 0, then issues PRE, clears the open bit, and moves to WAIT_RP.
REQ-019 WAIT_RP lasts so that ACT is issued exactly tRP cycles after PRE.
REQ-020 ACT issues immediately, sets the open bit and row, and moves to WAIT_RCD.
REQ-021 WAIT_RCD lasts so that the column command is issued exactly tRCD cycles after ACT.
REQ-022 CAS waits until the global CAS counter is 0, then issues RD (mode != 1) or WR (mode = 1), pulses req_done, and returns to IDLE.
REQ-023 Each CAS issue loads the global CAS counter with tCCD_L-1; the counter decrements each cycle and saturates at 0, so successive RD/WR are at least tCCD_L cycles apart.
REQ-024 Each RD loads that bank's eligibility counter with tRTP-1; each WR loads it with tWR-1; all 16 counters decrement in parallel and saturate at 0.
REQ-025 PRE follows RD/WR to the same bank by at least tRTP or tWR cycles respectively.
REQ-026 A state with a timing wait pending holds without issuing any command.
REQ-027 Minimum latency, counted from the acceptance cycle (cycle 0), with all counters at 0:
- hit: RD/WR at cycle 2
- empty: ACT at cycle 2, RD/WR at cycle 26
- conflict: PRE at cycle 2, ACT at cycle 26, RD/WR at cycle 50
REQ-028 Only one command issues per cycle; cmd_* outputs are registered.
REQ-029 Outside command cycles, cmd_* fields hold their last value.
REQ-030 A request to a bank in another bank group still obeys tCCD_L; tCCD_S is not modelled.

Reset
REQ-031 On rst_n low, the following take effect immediately, mid-command included:
- FSM to IDLE
- all open bits cleared
- all counters 0
- cmd_valid, req_done and req_ready = 0
- cmd_type = PRE, all other cmd_* fields 0
REQ-032 req_ready rises in the first clock after rst_n deasserts.
REQ-033 A request in flight during reset is discarded and never completes.
REQ-034 Row-table contents other than the open bits are don't-care after reset.

Structure
REQ-035 The shared package mem_cont_defs holds:
- timing parameters
- the dramCmd enum
- address field positions
- the mode encoding
REQ-036 The bank state (open bits, rows, eligibility counters) is a sub-module bank_state_table, with a lookup port and update ports for ACT, PRE, RD and WR.
REQ-037 The FSM, the CAS counter and the sequencing counter reside in mem_cmd_scheduler.

Verification
REQ-038 Reset, then read of address 0x0_0004_0000 (row 1, bank 0, bg 0) -> ACT (bg0, bank0, row 1) at cycle 2, RD (col 0) at cycle 26.
REQ-039 Same row, bank and bg, column 5, write issued right after the read -> WR no earlier than 8 cycles after the previous RD, no ACT.
REQ-040 Read row 2, same bank, right after the write -> PRE no earlier than 20 cycles after WR, ACT 24 cycles after PRE, RD 24 cycles after ACT.
REQ-041 Back-to-back hits in bg0 and bg3 -> RD/WR spaced exactly 8 cycles.
REQ-042 Assert rst_n low in WAIT_RCD -> all outputs reset immediately; the next request to the same bank issues ACT (bank was closed).
REQ-043 Mode 2 request -> issues RD; req_ready stays low from acceptance until the cycle after req_done.

Source files
------------

// File: rtl/mem_cont_defs.sv
// Shared DRAM controller definitions: timing, command encoding, address map, modes.
package mem_cont_defs;

  // DRAM timing in clk cycles
  localparam int T_RP    = 24;
  localparam int T_RCD   = 24;
  localparam int T_WR    = 20;
  localparam int T_RTP   = 12;
  localparam int T_CCD_L = 8;

  // Counter width; must hold the largest loaded value (tRP-2 / tWR-1)
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    CMD_PRE = 2'b00,
    CMD_ACT = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WR  = 2'b11
  } dram_cmd_e;

  // Address map: row [35:18], column [17:10], bank [9:8], bankGroup [7:6]
  localparam int ADDR_W   = 36;
  localparam int ROW_W    = 18;
  localparam int COL_W    = 8;
  localparam int BANK_W   = 2;
  localparam int BG_W     = 2;
  localparam int IDX_W    = BG_W + BANK_W;
  localparam int NBANKS   = 1 << IDX_W;
  localparam int ROW_LSB  = 18;
  localparam int COL_LSB  = 10;
  localparam int BANK_LSB = 8;
  localparam int BG_LSB   = 6;

  // Request modes; anything other than a write is served as a read
  localparam logic [3:0] MODE_RD = 4'd0;
  localparam logic [3:0] MODE_WR = 4'd1;
  localparam logic [3:0] MODE_IF = 4'd2;

  typedef struct packed {
    logic [BG_W-1:0]   bg;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } addr_fields_t;

  function automatic addr_fields_t decode_addr(input logic [ADDR_W-1:0] a);
    addr_fields_t f;
    f.bg   = a[BG_LSB   +: BG_W];
    f.bank = a[BANK_LSB +: BANK_W];
    f.row  = a[ROW_LSB  +: ROW_W];
    f.col  = a[COL_LSB  +: COL_W];
    return f;
  endfunction

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open-row tracking and precharge-eligibility counters.
module bank_state_table
  import mem_cont_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  // lookup
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_open,
  output logic [ROW_W-1:0] lk_row,
  output logic             lk_elig_zero,
  // updates
  input  logic             act_en,
  input  logic [IDX_W-1:0] act_idx,
  input  logic [ROW_W-1:0] act_row,
  input  logic             pre_en,
  input  logic [IDX_W-1:0] pre_idx,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] cas_idx
);

  logic [NBANKS-1:0]            open_q;
  logic [NBANKS-1:0][ROW_W-1:0] row_q;
  logic [NBANKS-1:0][CNT_W-1:0] elig_q;

  assign lk_open      = open_q[lk_idx];
  assign lk_row       = row_q[lk_idx];
  assign lk_elig_zero = (elig_q[lk_idx] == '0);

  // Open bits: PRE closes, ACT opens (never both on one bank in one cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
    end else begin
      if (pre_en) open_q[pre_idx] <= 1'b0;
      if (act_en) open_q[act_idx] <= 1'b1;
    end
  end

  // Row storage; contents only meaningful while the open bit is set
  always_ff @(posedge clk) begin
    if (act_en) row_q[act_idx] <= act_row;
  end

  // Eligibility counters: load on RD/WR, otherwise count down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elig_q <= '0;
    end else begin
      for (int i = 0; i < NBANKS; i++) begin
        if ((rd_en || wr_en) && cas_idx == IDX_W'(i))
          elig_q[i] <= wr_en ? CNT_W'(T_WR - 1) : CNT_W'(T_RTP - 1);
        else if (elig_q[i] != '0)
          elig_q[i] <= elig_q[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_cmd_scheduler.sv
// In-order, single-outstanding, open-page DRAM command scheduler.
module mem_cmd_scheduler
  import mem_cont_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  output logic [1:0]        cmd_type,
  output logic [BG_W-1:0]   cmd_bg,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              req_done
);

  typedef enum logic [2:0] {
    IDLE, DECODE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   mode_q;
  addr_fields_t f_q;
  logic [CNT_W-1:0] seq_cnt_q;
  logic [CNT_W-1:0] cas_cnt_q;
  logic         ready_q;

  logic         do_pre, do_act, do_cas;
  logic         accept, is_wr;
  logic         lk_open, lk_elig_zero;
  logic [ROW_W-1:0] lk_row;
  logic [IDX_W-1:0] idx;

  dram_cmd_e    cmd_type_q;

  assign accept    = req_valid && ready_q;
  assign is_wr     = (mode_q == MODE_WR);
  assign idx       = {f_q.bg, f_q.bank};
  assign req_ready = ready_q;
  assign cmd_type  = cmd_type_q;

  bank_state_table u_banks (
    .clk          (clk),
    .rst_n        (rst_n),
    .lk_idx       (idx),
    .lk_open      (lk_open),
    .lk_row       (lk_row),
    .lk_elig_zero (lk_elig_zero),
    .act_en       (do_act),
    .act_idx      (idx),
    .act_row      (f_q.row),
    .pre_en       (do_pre),
    .pre_idx      (idx),
    .rd_en        (do_cas && !is_wr),
    .wr_en        (do_cas && is_wr),
    .cas_idx      (idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and command-issue decisions
  always_comb begin
    state_d = state_q;
    do_pre  = 1'b0;
    do_act  = 1'b0;
    do_cas  = 1'b0;
    unique case (state_q)
      IDLE:     if (accept) state_d = DECODE;
      DECODE: begin
        if (!lk_open)             state_d = ACT;
        else if (lk_row == f_q.row) state_d = CAS;
        else                      state_d = PRE;
      end
      PRE: begin
        if (lk_elig_zero) begin
          do_pre  = 1'b1;
          state_d = WAIT_RP;
        end
      end
      WAIT_RP:  if (seq_cnt_q == '0) state_d = ACT;
      ACT: begin
        do_act  = 1'b1;
        state_d = WAIT_RCD;
      end
      WAIT_RCD: if (seq_cnt_q == '0) state_d = CAS;
      CAS: begin
        if (cas_cnt_q == '0) begin
          do_cas  = 1'b1;
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Request latch on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RD;
      f_q    <= '0;
    end else if (accept) begin
      mode_q <= req_mode;
      f_q    <= decode_addr(req_addr);
    end
  end

  // Ready is registered so it stays low in reset and rises one clock after
  // the FSM is back in IDLE; it drops in the accepting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= (state_q == IDLE) && !accept;
  end

  // Sequencing counter: the wait state plus the next command state span
  // the full tRP/tRCD, hence the load of t-2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               seq_cnt_q <= '0;
    else if (do_pre)          seq_cnt_q <= CNT_W'(T_RP - 2);
    else if (do_act)          seq_cnt_q <= CNT_W'(T_RCD - 2);
    else if (seq_cnt_q != '0) seq_cnt_q <= seq_cnt_q - CNT_W'(1);
  end

  // Global CAS spacing counter (tCCD_L across all bank groups)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cas_cnt_q <= '0;
    else if (do_cas)          cas_cnt_q <= CNT_W'(T_CCD_L - 1);
    else if (cas_cnt_q != '0) cas_cnt_q <= cas_cnt_q - CNT_W'(1);
  end

  // Registered command outputs; fields hold between commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      req_done   <= 1'b0;
      cmd_type_q <= CMD_PRE;
      cmd_bg     <= '0;
      cmd_bank   <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
    end else begin
      cmd_valid <= do_pre || do_act || do_cas;
      req_done  <= do_cas;
      if (do_pre || do_act || do_cas) begin
        cmd_bg   <= f_q.bg;
        cmd_bank <= f_q.bank;
      end
      if (do_pre) cmd_type_q <= CMD_PRE;
      if (do_act) begin
        cmd_type_q <= CMD_ACT;
        cmd_row    <= f_q.row;
      end
      if (do_cas) begin
        cmd_type_q <= is_wr ? CMD_WR : CMD_RD;
        cmd_col    <= f_q.col;
      end
    end
  end

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed scoreboard bench for mem_cmd_scheduler.
module tb_mem_cmd_scheduler;
  import mem_cont_defs::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_mode;
  logic [35:0] req_addr;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [17:0] cmd_row;
  logic [7:0]  cmd_col;
  logic        req_done;

  mem_cmd_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .req_done  (req_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc is the number of the last rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [17:0] row;
    logic [7:0]  col;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  // Reference timing model (spec-level: earliest legal edge for each command)
  bit          m_open [16];
  logic [17:0] m_row  [16];
  int          m_elig [16];
  int          m_last_cas;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
      m_elig[i] = 0;
    end
    m_last_cas = -1000;
  endtask

  task automatic push(input logic [1:0] t, input logic [1:0] bg, input logic [1:0] bank,
                      input logic [17:0] row, input logic [7:0] col, input int at);
    exp_t e;
    e.t = t; e.bg = bg; e.bank = bank; e.at = at;
    e.row = (t == 2'b01) ? row : 18'd0;
    e.col = (t[1]) ? col : 8'd0;
    exp_q.push_back(e);
  endtask

  // Issue one request; abort=1 expects only the commands before the column
  // command (the request is killed by reset before it completes).
  task automatic send(input logic [3:0] mode, input logic [17:0] row, input logic [7:0] col,
                      input logic [1:0] bank, input logic [1:0] bg, input bit abort,
                      output int acc);
    int n = 0;
    int pre_t, act_t, cas_t;
    logic [3:0] idx;
    bit wr;
    acc = 0;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", {63'd0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = {row, col, bank, bg, 6'h2a};
    acc = cyc + 1;
    idx = {bg, bank};
    wr  = (mode == 4'd1);
    if (m_open[idx] && m_row[idx] == row) begin
      cas_t = imax(acc + 2, m_last_cas + 8);
    end else if (!m_open[idx]) begin
      act_t = acc + 2;
      push(2'b01, bg, bank, row, col, act_t);
      cas_t = imax(act_t + 24, m_last_cas + 8);
    end else begin
      pre_t = imax(acc + 2, m_elig[idx]);
      push(2'b00, bg, bank, row, col, pre_t);
      act_t = pre_t + 24;
      push(2'b01, bg, bank, row, col, act_t);
      cas_t = imax(act_t + 24, m_last_cas + 8);
    end
    if (!abort) begin
      push(wr ? 2'b11 : 2'b10, bg, bank, row, col, cas_t);
      m_open[idx] = 1'b1;
      m_row[idx]  = row;
      m_last_cas  = cas_t;
      m_elig[idx] = cas_t + (wr ? 20 : 12);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every command is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cmd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", {63'd0, cmd_valid}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmd_fields",
              {32'd0, cmd_type, cmd_bg, cmd_bank,
               (cmd_type == 2'b01) ? cmd_row : 18'd0,
               cmd_type[1] ? cmd_col : 8'd0},
              {32'd0, e.t, e.bg, e.bank, e.row, e.col});
          chk("cmd_cycle", 64'(cyc), 64'(e.at));
          chk("req_done_with_cas", {63'd0, req_done}, {63'd0, e.t[1]});
        end
      end else if (req_done === 1'b1) begin
        chk("stray_req_done", {63'd0, req_done}, 64'd0);
      end
    end
  end

  initial begin
    int acc;
    int n;
    req_valid = 1'b0;
    req_mode  = '0;
    req_addr  = '0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {29'd0, cmd_valid, req_done, req_ready, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col},
        64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_low_before_first_clk", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Empty bank read, then hit write, then row conflict read
    send(4'd0, 18'd1, 8'd0, 2'd0, 2'd0, 1'b0, acc);
    send(4'd1, 18'd1, 8'd5, 2'd0, 2'd0, 1'b0, acc);
    send(4'd0, 18'd2, 8'd3, 2'd0, 2'd0, 1'b0, acc);

    // Open bg3, then back-to-back hits alternating bank groups
    send(4'd0, 18'd3, 8'd1, 2'd0, 2'd3, 1'b0, acc);
    send(4'd1, 18'd2, 8'd7, 2'd0, 2'd0, 1'b0, acc);
    send(4'd0, 18'd3, 8'd9, 2'd0, 2'd3, 1'b0, acc);
    // Conflict right after a read: PRE bounded by tRTP
    send(4'd0, 18'd4, 8'd2, 2'd0, 2'd3, 1'b0, acc);
    // Unrecognised mode served as a read
    send(4'd5, 18'd4, 8'd6, 2'd0, 2'd3, 1'b0, acc);
    drain();

    // Instruction fetch: ready stays low until the cycle after req_done
    send(4'd2, 18'd4, 8'hff, 2'd0, 2'd3, 1'b0, acc);
    n = 0;
    while (req_done !== 1'b1 && n < 100) begin
      chk("ready_low_busy", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'd0, req_done}, 64'd1);
    chk("ready_low_at_done", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("ready_after_done", {63'd0, req_ready}, 64'd1);
    drain();

    // Reset while in WAIT_RCD; the read must never appear
    send(4'd0, 18'd7, 8'd4, 2'd1, 2'd1, 1'b1, acc);
    n = 0;
    while (cyc < acc + 10 && n < 50) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_cmd_outputs",
        {29'd0, cmd_valid, req_done, req_ready, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col},
        64'd0);
    chk("act_before_reset_seen", 64'(exp_q.size()), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'd0, 18'd7, 8'd4, 2'd1, 2'd1, 1'b0, acc);
    drain();
    repeat (40) @(negedge clk);
    chk("no_trailing_cmds", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
